c_instr_aligner: RTL and testbench

- Halfword-granular fetch realigner between the instruction fetch port and the decoder, for RV32IC.
- Accepts FETCH_W-bit aligned fetch words and buffers them as 16-bit parcels.
- Emits one instruction per handshake: a compressed instruction (low bits != 2'b11), or a 32-bit instruction that may straddle fetch words.
- Generalises the fixed 16-bit C-extension view to configurable fetch width and buffer depth, and adds PC tracking, misaligned-start skipping and flush.

---
 rtl/c_instr_aligner_pkg.sv | 13 +
 rtl/c_instr_aligner_if.sv | 34 +++
 rtl/c_parcel_fifo.sv | 72 +++++++
 rtl/c_instr_aligner.sv | 77 +++++++
 tb/tb_c_instr_aligner.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/c_instr_aligner_pkg.sv
// rtl/c_instr_aligner_pkg.sv - shared RV32C parcel definitions for the fetch aligner
package c_instr_aligner_pkg;

  localparam int PARCEL_W = 16;

  // Low two bits of a full-length (32-bit or longer) encoding.
  localparam logic [1:0] OPCODE_NC = 2'b11;

  function automatic logic is_compressed(input logic [PARCEL_W-1:0] parcel);
    return parcel[1:0] != OPCODE_NC;
  endfunction

endpackage

// File: rtl/c_instr_aligner_if.sv
// rtl/c_instr_aligner_if.sv - fetch/decode handshake bundle for the aligner
// Ports (signals):
//   flush, flush_pc                           restart request and address
//   fetch_valid, fetch_ready, fetch_data      fetch word stream into the aligner
//   instr_valid, instr_ready, instr_data,
//   instr_pc, instr_compressed, instr_c_zero  realigned instruction stream out
// Modports: slave = aligner side, master = fetch unit / decoder side.
interface c_instr_aligner_if #(
  parameter int FETCH_W = 32
);
  logic               flush;
  logic [31:0]        flush_pc;
  logic               fetch_valid;
  logic               fetch_ready;
  logic [FETCH_W-1:0] fetch_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr_data;
  logic [31:0]        instr_pc;
  logic               instr_compressed;
  logic               instr_c_zero;

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_data, instr_ready,
    output fetch_ready, instr_valid, instr_data, instr_pc,
           instr_compressed, instr_c_zero
  );

  modport master (
    output flush, flush_pc, fetch_valid, fetch_data, instr_ready,
    input  fetch_ready, instr_valid, instr_data, instr_pc,
           instr_compressed, instr_c_zero
  );
endinterface

// File: rtl/c_parcel_fifo.sv
// rtl/c_parcel_fifo.sv - circular 16-bit parcel FIFO with multi-lane push and 1/2-parcel pop
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             empty the FIFO and rewind both pointers to 0
//   push, skip_first  write LANES parcels (lane 0 dropped when skip_first)
//   push_data         LANES parcels, lane 0 in the low 16 bits
//   pop, pop_two      remove 1 parcel, or 2 when pop_two
//   head0, head1      parcel at head and the one after it
//   count             number of parcels held (0..BUF_HW)
module c_parcel_fifo
  import c_instr_aligner_pkg::*;
#(
  parameter int BUF_HW = 6,
  parameter int LANES  = 2,
  parameter int PW     = (BUF_HW > 1) ? $clog2(BUF_HW) : 1,
  parameter int CW     = $clog2(BUF_HW + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      skip_first,
  input  logic [LANES*PARCEL_W-1:0] push_data,
  input  logic                      pop,
  input  logic                      pop_two,
  output logic [PARCEL_W-1:0]       head0,
  output logic [PARCEL_W-1:0]       head1,
  output logic [CW-1:0]             count
);

  logic [PARCEL_W-1:0] mem [BUF_HW];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       n_push;
  logic [CW-1:0]       n_pop;

  // Offsets never exceed BUF_HW-1, so a single conditional subtract gives
  // correct wrap even when BUF_HW is not a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= 32'(BUF_HW)) s = s - 32'(BUF_HW);
    return PW'(s);
  endfunction

  assign n_push = push ? (skip_first ? CW'(LANES - 1) : CW'(LANES)) : '0;
  assign n_pop  = pop ? (pop_two ? CW'(2) : CW'(1)) : '0;

  assign head0 = mem[head];
  assign head1 = mem[wrap_add(head, 1)];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        // Surviving lanes are packed contiguously starting at tail.
        for (int i = 0; i < LANES; i++) begin
          if (!(skip_first && i == 0)) begin
            mem[wrap_add(tail, 32'(i) - 32'(skip_first))] <= push_data[i*PARCEL_W +: PARCEL_W];
          end
        end
        tail <= wrap_add(tail, 32'(n_push));
      end
      if (pop) head <= wrap_add(head, 32'(n_pop));
      count <= count + n_push - n_pop;
    end
  end

endmodule

// File: rtl/c_instr_aligner.sv
// rtl/c_instr_aligner.sv - RV32IC halfword fetch realigner between fetch port and decoder
// Ports:
//   p_clk, p_reset  clock, synchronous active-high reset (priority over flush)
//   bus (slave)     flush/flush_pc, fetch_* word stream in, instr_* instruction stream out
module c_instr_aligner
  import c_instr_aligner_pkg::*;
#(
  parameter int          FETCH_W  = 32,
  parameter int          BUF_HW   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              p_clk,
  input logic              p_reset,
  c_instr_aligner_if.slave bus
);

  localparam int LANES = FETCH_W / PARCEL_W;
  localparam int CW    = $clog2(BUF_HW + 1);

  logic [CW-1:0]       count;
  logic [PARCEL_W-1:0] head0;
  logic [PARCEL_W-1:0] head1;
  logic [31:0]         pc;
  logic                skip;
  logic                head_c;
  logic                fetch_hs;
  logic                instr_hs;

  assign head_c = is_compressed(head0);

  // Free space from registered count only, so a same-cycle pop cannot
  // open the fetch port combinationally.
  assign bus.fetch_ready = (32'(BUF_HW) - 32'(count)) >= 32'(LANES);

  // A 32-bit instruction waits at the head until its upper parcel lands.
  assign bus.instr_valid      = head_c ? (count >= CW'(1)) : (count >= CW'(2));
  assign bus.instr_data       = head_c ? {16'h0000, head0} : {head1, head0};
  assign bus.instr_pc         = pc;
  assign bus.instr_compressed = head_c;
  assign bus.instr_c_zero     = head_c && (head0 == 16'h0000);

  assign fetch_hs = bus.fetch_valid && bus.fetch_ready && !bus.flush;
  assign instr_hs = bus.instr_valid && bus.instr_ready && !bus.flush;

  c_parcel_fifo #(
    .BUF_HW (BUF_HW),
    .LANES  (LANES)
  ) u_fifo (
    .clk        (p_clk),
    .rst        (p_reset),
    .clear      (bus.flush),
    .push       (fetch_hs),
    .skip_first (skip),
    .push_data  (bus.fetch_data),
    .pop        (instr_hs),
    .pop_two    (!head_c),
    .head0      (head0),
    .head1      (head1),
    .count      (count)
  );

  // skip marks a restart on the odd halfword of a fetch word: the first
  // parcel of the next fetch precedes the target and is dropped.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      pc   <= RESET_PC;
      skip <= RESET_PC[1];
    end else if (bus.flush) begin
      pc   <= bus.flush_pc & ~32'h1;
      skip <= bus.flush_pc[1];
    end else begin
      if (instr_hs) pc <= pc + (head_c ? 32'd2 : 32'd4);
      if (fetch_hs) skip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_c_instr_aligner.sv
// tb/tb_c_instr_aligner.sv - directed self-checking bench for c_instr_aligner
module tb_c_instr_aligner;

  logic p_clk = 1'b0;
  logic p_reset;
  int   tests = 0;
  int   fails = 0;

  always #5 p_clk = ~p_clk;

  c_instr_aligner_if #(.FETCH_W(32)) a ();
  c_instr_aligner_if #(.FETCH_W(64)) b ();

  c_instr_aligner #(.FETCH_W(32), .BUF_HW(6), .RESET_PC(32'h0)) dut32 (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .bus     (a)
  );

  c_instr_aligner #(.FETCH_W(64), .BUF_HW(6), .RESET_PC(32'h0)) dut64 (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .bus     (b)
  );

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic idle_inputs();
    a.flush = 0; a.flush_pc = '0; a.fetch_valid = 0; a.fetch_data = '0; a.instr_ready = 0;
    b.flush = 0; b.flush_pc = '0; b.fetch_valid = 0; b.fetch_data = '0; b.instr_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    p_reset = 1;
    tick();
    tick();
    p_reset = 0;
  endtask

  task automatic push_a(input logic [31:0] w);
    a.fetch_valid = 1;
    a.fetch_data  = w;
    tick();
    a.fetch_valid = 0;
  endtask

  task automatic drain_a(input int n);
    a.instr_ready = 1;
    repeat (n) tick();
    a.instr_ready = 0;
  endtask

  function automatic logic [15:0] bp_parcel(input int i);
    return 16'h2000 + 16'(i * 16);
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (a.instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid32 got %b exp 0", a.instr_valid); end
    tests++; if (a.fetch_ready !== 1'b1) begin fails++; $display("FAIL reset_ready32 got %b exp 1", a.fetch_ready); end
    tests++; if (a.instr_pc !== 32'h0) begin fails++; $display("FAIL reset_pc32 got %h exp 0", a.instr_pc); end
    tests++; if (b.instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid64 got %b exp 0", b.instr_valid); end
    tests++; if (b.fetch_ready !== 1'b1) begin fails++; $display("FAIL reset_ready64 got %b exp 1", b.fetch_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    push_a(32'h0001_4501);
    #1;
    tests++; if (a.instr_valid !== 1'b1) begin fails++; $display("FAIL basic_valid0 got %b exp 1", a.instr_valid); end
    tests++; if (a.instr_data !== 32'h0000_4501) begin fails++; $display("FAIL basic_data0 got %h exp 00004501", a.instr_data); end
    tests++; if (a.instr_pc !== 32'h0) begin fails++; $display("FAIL basic_pc0 got %h exp 0", a.instr_pc); end
    tests++; if (a.instr_compressed !== 1'b1) begin fails++; $display("FAIL basic_comp0 got %b exp 1", a.instr_compressed); end
    a.instr_ready = 1;
    tick(); #1;
    tests++; if (a.instr_data !== 32'h0000_0001) begin fails++; $display("FAIL basic_data1 got %h exp 00000001", a.instr_data); end
    tests++; if (a.instr_pc !== 32'h2) begin fails++; $display("FAIL basic_pc1 got %h exp 2", a.instr_pc); end
    tests++; if (a.instr_c_zero !== 1'b0) begin fails++; $display("FAIL basic_czero1 got %b exp 0", a.instr_c_zero); end
    tick();
    a.instr_ready = 0;
    #1;
    tests++; if (a.instr_valid !== 1'b0) begin fails++; $display("FAIL basic_empty got %b exp 0", a.instr_valid); end
  endtask

  task automatic test_straddle();
    do_reset();
    push_a(32'h0093_0001);
    #1;
    tests++; if (a.instr_data !== 32'h0000_0001 || a.instr_pc !== 32'h0) begin fails++; $display("FAIL straddle_first got %h@%h exp 00000001@0", a.instr_data, a.instr_pc); end
    a.instr_ready = 1;
    tick(); #1;
    tests++; if (a.instr_valid !== 1'b0) begin fails++; $display("FAIL straddle_half_valid got %b exp 0", a.instr_valid); end
    tick(); #1;
    tests++; if (a.instr_valid !== 1'b0) begin fails++; $display("FAIL straddle_half_hold got %b exp 0", a.instr_valid); end
    a.instr_ready = 0;
    push_a(32'h0000_0010);
    #1;
    tests++; if (a.instr_valid !== 1'b1) begin fails++; $display("FAIL straddle_valid got %b exp 1", a.instr_valid); end
    tests++; if (a.instr_data !== 32'h0010_0093) begin fails++; $display("FAIL straddle_data got %h exp 00100093", a.instr_data); end
    tests++; if (a.instr_pc !== 32'h2) begin fails++; $display("FAIL straddle_pc got %h exp 2", a.instr_pc); end
    tests++; if (a.instr_compressed !== 1'b0) begin fails++; $display("FAIL straddle_comp got %b exp 0", a.instr_compressed); end
    a.instr_ready = 1;
    tick();
    a.instr_ready = 0;
    #1;
    tests++; if (a.instr_pc !== 32'h6) begin fails++; $display("FAIL straddle_pc_after got %h exp 6", a.instr_pc); end
    tests++; if (a.instr_c_zero !== 1'b1 || a.instr_valid !== 1'b1) begin fails++; $display("FAIL straddle_czero got %b/%b exp 1/1", a.instr_c_zero, a.instr_valid); end
    drain_a(1);
  endtask

  task automatic test_flush();
    do_reset();
    push_a(32'h0001_4501);
    a.flush = 1; a.flush_pc = 32'h0000_0102;
    tick();
    a.flush = 0;
    #1;
    tests++; if (a.instr_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", a.instr_valid); end
    push_a(32'h0001_FFFF);
    #1;
    tests++; if (a.instr_data !== 32'h0000_0001) begin fails++; $display("FAIL flush_data got %h exp 00000001", a.instr_data); end
    tests++; if (a.instr_pc !== 32'h0000_0102) begin fails++; $display("FAIL flush_pc got %h exp 00000102", a.instr_pc); end
    a.instr_ready = 1;
    tick();
    a.instr_ready = 0;
    #1;
    tests++; if (a.instr_valid !== 1'b0) begin fails++; $display("FAIL flush_single got %b exp 0", a.instr_valid); end
    push_a(32'h0001_4501);
    #1;
    tests++; if (a.instr_data !== 32'h0000_4501 || a.instr_pc !== 32'h0000_0104) begin fails++; $display("FAIL flush_noskip got %h@%h exp 00004501@00000104", a.instr_data, a.instr_pc); end
    drain_a(2);
  endtask

  task automatic test_backpressure();
    int accepted;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a.fetch_valid = 1;
      a.fetch_data  = {bp_parcel(2*k+1), bp_parcel(2*k)};
      #1;
      tests++; if (a.fetch_ready !== (k < 3)) begin fails++; $display("FAIL bp_ready%0d got %b exp %b", k, a.fetch_ready, (k < 3)); end
      if (k < 3) tick();
    end
    accepted = 0;
    a.instr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (a.instr_valid !== 1'b1 || a.instr_data !== {16'h0, bp_parcel(i)} || a.instr_pc !== 32'(2*i)) begin
        fails++;
        $display("FAIL bp_item%0d got v=%b %h@%h exp v=1 %h@%h", i, a.instr_valid, a.instr_data, a.instr_pc, {16'h0, bp_parcel(i)}, 32'(2*i));
      end
      if (a.fetch_valid && a.fetch_ready) accepted++;
      tick();
      if (accepted != 0) a.fetch_valid = 0;
      #1;
    end
    a.instr_ready = 0;
    tests++; if (accepted != 1) begin fails++; $display("FAIL bp_accept got %0d exp 1", accepted); end
    tests++; if (a.instr_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %b exp 0", a.instr_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    push_a(32'h0001_4501);
    a.flush = 1; a.flush_pc = 32'h0000_0200;
    a.fetch_valid = 1; a.fetch_data = 32'h0005_0009;
    a.instr_ready = 1;
    #1;
    tests++; if (a.instr_valid !== 1'b1 || a.fetch_ready !== 1'b1) begin fails++; $display("FAIL simul_pre got v=%b r=%b exp 1/1", a.instr_valid, a.fetch_ready); end
    tick();
    idle_inputs();
    #1;
    tests++; if (a.instr_valid !== 1'b0 || a.fetch_ready !== 1'b1) begin fails++; $display("FAIL simul_empty got v=%b r=%b exp 0/1", a.instr_valid, a.fetch_ready); end
    push_a(32'h0001_4501);
    #1;
    tests++; if (a.instr_data !== 32'h0000_4501 || a.instr_pc !== 32'h0000_0200) begin fails++; $display("FAIL simul_next got %h@%h exp 00004501@00000200", a.instr_data, a.instr_pc); end
    drain_a(2);
  endtask

  task automatic test_pc_wrap();
    do_reset();
    a.flush = 1; a.flush_pc = 32'hFFFF_FFFE;
    tick();
    a.flush = 0;
    push_a(32'h0001_4501);
    #1;
    tests++; if (a.instr_data !== 32'h0000_0001 || a.instr_pc !== 32'hFFFF_FFFE) begin fails++; $display("FAIL wrap_top got %h@%h exp 00000001@fffffffe", a.instr_data, a.instr_pc); end
    push_a(32'h0000_4505);
    a.instr_ready = 1;
    tick();
    a.instr_ready = 0;
    #1;
    tests++; if (a.instr_data !== 32'h0000_4505 || a.instr_pc !== 32'h0) begin fails++; $display("FAIL wrap_zero got %h@%h exp 00004505@00000000", a.instr_data, a.instr_pc); end
    drain_a(2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_a(32'h0005_4501);
    p_reset = 1; a.flush = 1; a.flush_pc = 32'h0000_0300;
    tick();
    p_reset = 0; a.flush = 0;
    #1;
    tests++; if (a.instr_valid !== 1'b0 || a.fetch_ready !== 1'b1) begin fails++; $display("FAIL rstmid_state got v=%b r=%b exp 0/1", a.instr_valid, a.fetch_ready); end
    push_a(32'h0001_4501);
    #1;
    tests++; if (a.instr_data !== 32'h0000_4501 || a.instr_pc !== 32'h0) begin fails++; $display("FAIL rstmid_pc got %h@%h exp 00004501@00000000", a.instr_data, a.instr_pc); end
    drain_a(2);
  endtask

  task automatic test_wide();
    do_reset();
    b.fetch_valid = 1;
    b.fetch_data  = 64'h0000_0000_0001_0001;
    #1;
    tests++; if (b.fetch_ready !== 1'b1) begin fails++; $display("FAIL wide_ready0 got %b exp 1", b.fetch_ready); end
    tick();
    b.fetch_valid = 0;
    #1;
    tests++; if (b.fetch_ready !== 1'b0) begin fails++; $display("FAIL wide_ready1 got %b exp 0", b.fetch_ready); end
    tests++; if (b.instr_data !== 32'h0000_0001 || b.instr_pc !== 32'h0) begin fails++; $display("FAIL wide_i0 got %h@%h exp 00000001@0", b.instr_data, b.instr_pc); end
    b.instr_ready = 1;
    tick(); #1;
    tests++; if (b.instr_data !== 32'h0000_0001 || b.instr_pc !== 32'h2) begin fails++; $display("FAIL wide_i1 got %h@%h exp 00000001@2", b.instr_data, b.instr_pc); end
    tick(); #1;
    tests++; if (b.instr_c_zero !== 1'b1 || b.instr_compressed !== 1'b1 || b.instr_pc !== 32'h4) begin fails++; $display("FAIL wide_i2 got cz=%b c=%b @%h exp 1/1@4", b.instr_c_zero, b.instr_compressed, b.instr_pc); end
    tick(); #1;
    tests++; if (b.instr_c_zero !== 1'b1 || b.instr_valid !== 1'b1 || b.instr_pc !== 32'h6) begin fails++; $display("FAIL wide_i3 got cz=%b v=%b @%h exp 1/1@6", b.instr_c_zero, b.instr_valid, b.instr_pc); end
    tick();
    b.instr_ready = 0;
    #1;
    tests++; if (b.instr_valid !== 1'b0 || b.fetch_ready !== 1'b1) begin fails++; $display("FAIL wide_end got v=%b r=%b exp 0/1", b.instr_valid, b.fetch_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    p_reset = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_straddle();
    test_flush();
    test_backpressure();
    test_simultaneous();
    test_pc_wrap();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
